// File: rtl/ram8_load_arbiter_pkg.sv
// Shared types and constants for the RAM8 load arbiter.
// The optional burst mode is enabled by defining ARB_BURST_EN.
package ram8_load_arbiter_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/ram8_load_arbiter_rr_pick8.sv
// Combinational round-robin picker: first set request scanning ptr+1, ptr+2, ...
// modulo 8, so the previous winner has the lowest priority.
module rr_pick8
    import ram8_load_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               valid,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] pos;

    always_comb begin
        valid = |req;
        idx   = '0;
        pos   = '0;
        // Walk from the farthest candidate back to ptr+1 so the nearest one wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos = ptr + SEL_W'(k);
            if (req[pos]) begin
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/ram8_load_arbiter.sv
// Round-robin arbiter driving one RAM8 bank (sel/load/out) on behalf of 8 writers.
// Define ARB_BURST_EN to let a winner keep the grant for up to MAX_BURST writes.
module ram8_load_arbiter
    import ram8_load_arbiter_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       burst,
    input  logic [NUM_REQ*WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]       ack,
    output logic [SEL_W-1:0]         sel,
    output logic                     load,
    output logic [WIDTH-1:0]         out,
    output logic                     busy
);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] word [NUM_REQ];
    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;
    logic             burst_more;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
            assign word[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    logic [CNT_W-1:0] count_q, count_d;

    assign burst_more = req[sel_q] && burst[sel_q] && (count_q < CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`else
    logic unused_burst;
    assign unused_burst = ^{burst, (MAX_BURST >= 1)};
    assign burst_more   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        out_d   = out_q;
`ifdef ARB_BURST_EN
        count_d = count_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    out_d   = word[pick_idx];
                    state_d = ST_WRITE;
`ifdef ARB_BURST_EN
                    count_d = '0;
`endif
                end
            end
            ST_WRITE: begin
                ptr_d   = sel_q;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                // A continuing burst refreshes only the word; sel and ptr already name the winner.
                if (burst_more) begin
                    out_d   = word[sel_q];
                    state_d = ST_WRITE;
`ifdef ARB_BURST_EN
                    count_d = count_q + 1'b1;
`endif
                end else begin
                    state_d = ST_IDLE;
`ifdef ARB_BURST_EN
                    count_d = '0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'd7;
            sel_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
        end
    end

    // Strobes decode straight from the state register so an async reset kills them at once.
    assign load = (state_q == ST_WRITE);
    assign ack  = load ? onehot8(sel_q) : '0;
    assign busy = (state_q != ST_IDLE);
    assign sel  = sel_q;
    assign out  = out_q;

endmodule

// File: tb/tb_ram8_load_arbiter.sv
// Bench for ram8_load_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model (burst mode when ARB_BURST_EN is defined).
module tb_ram8_load_arbiter;

    localparam int WIDTH     = 16;
    localparam int MAX_BURST = 4;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic [7:0]           req   = '0;
    logic [7:0]           burst = '0;
    logic [8*WIDTH-1:0]   wdata = '0;
    logic [7:0]           ack;
    logic [2:0]           sel;
    logic                 load;
    logic [WIDTH-1:0]     out;
    logic                 busy;

    always #5 clk = ~clk;

    ram8_load_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .burst (burst),
        .wdata (wdata),
        .ack   (ack),
        .sel   (sel),
        .load  (load),
        .out   (out),
        .busy  (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int prev_cyc = 0;
    int gap_cyc  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] word_of(input int i);
        return wdata[i*WIDTH +: WIDTH];
    endfunction

    task automatic set_word(input int i, input logic [WIDTH-1:0] v);
        wdata[i*WIDTH +: WIDTH] = v;
    endtask

    // Transaction model: m_slot counts position in a grant (0 none, 1 write cycle, 2 gap).
    int               m_slot = 0;
    int               m_ptr  = 7;
    int               m_win  = 0;
    int               m_cnt  = 0;
    int               m_found;
    logic [WIDTH-1:0] m_out  = '0;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_slot = 0; m_ptr = 7; m_win = 0; m_cnt = 0; m_out = '0;
        end else if (m_slot == 0) begin
            if (req != 8'h00) begin
                m_found = -1;
                for (int k = 8; k >= 1; k--) if (req[(m_ptr + k) % 8]) m_found = (m_ptr + k) % 8;
                m_win  = m_found;
                m_out  = word_of(m_win);
                m_cnt  = 0;
                m_slot = 1;
            end
        end else if (m_slot == 1) begin
            m_ptr  = m_win;
            m_slot = 2;
        end else begin
`ifdef ARB_BURST_EN
            if (req[m_win] && burst[m_win] && (m_cnt < MAX_BURST - 1)) begin
                m_cnt++;
                m_out  = word_of(m_win);
                m_slot = 1;
            end else begin
                m_cnt  = 0;
                m_slot = 0;
            end
`else
            m_slot = 0;
`endif
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("load", 64'(load), 64'(m_slot == 1));
            chk("ack",  64'(ack),  64'((m_slot == 1) ? (8'h01 << m_win) : 8'h00));
            chk("sel",  64'(sel),  64'(m_win));
            chk("out",  64'(out),  64'(m_out));
            chk("busy", 64'(busy), 64'(m_slot != 0));
            if (load) $display("write: sel=%0d ack=%02h data=%04h", sel, ack, out);
        end
    end

    // Advances at least one cycle, then waits (bounded) for the next load pulse.
    task automatic wait_load(input string name, input int exp_sel);
        int i;
        i = 0;
        @(negedge clk);
        while (load !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_seen"}, 64'(load), 64'(1));
        chk(name, 64'(sel), 64'(exp_sel));
        gap_cyc  = cyc - prev_cyc;
        prev_cyc = cyc;
    endtask

    initial begin
        // 1: reset with all requests high
        req = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_ack",  64'(ack),  64'(0));
        chk("rst_load", 64'(load), 64'(0));
        chk("rst_sel",  64'(sel),  64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out",  64'(out),  64'(0));
        rst_n = 1'b1;

        // 3: round-robin order 0..7,0 with one load every 3 cycles
        wait_load("rr_first", 0);
        chk("rr_first_ack", 64'(ack), 64'(8'h01));
        for (int k = 1; k <= 8; k++) begin
            wait_load("rr_order", k % 8);
            chk("rr_ack", 64'(ack), 64'(8'h01 << (k % 8)));
            chk("rr_spacing", 64'(gap_cyc), 64'(3));
        end

        // 2: single writer 4
        req = 8'b0001_0000;
        set_word(4, 16'hBEEF);
        wait_load("single_sel", 4);
        chk("single_ack", 64'(ack), 64'(8'h10));
        chk("single_out", 64'(out), 64'(16'hBEEF));
        @(negedge clk);
        chk("single_load_drop", 64'(load), 64'(0));
        chk("single_sel_hold",  64'(sel),  64'(4));

        // 4: wrap from ptr=6 past unused writer 7
        req = 8'b0100_0000;
        wait_load("wrap_setup", 6);
        req = 8'b0000_0011;
        wait_load("wrap_first", 0);
        wait_load("wrap_second", 1);
        chk("wrap_spacing", 64'(gap_cyc), 64'(3));
        req = 8'h00;

        // 5: async reset in the middle of a write
        repeat (3) @(negedge clk);
        req = 8'b0010_0000;
        wait_load("midrst_sel", 5);
        req = 8'b0100_0001;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_load", 64'(load), 64'(0));
        chk("midrst_ack",  64'(ack),  64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        wait_load("midrst_restart", 0);
        req = 8'h00;
        repeat (3) @(negedge clk);

`ifdef ARB_BURST_EN
        // 6: burst of exactly MAX_BURST writes, then the pending writer 3
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'b0000_1100;
        burst = 8'b0000_0100;
        set_word(2, 16'hA000);
        for (int b = 0; b < MAX_BURST; b++) begin
            wait_load("burst_sel", 2);
            chk("burst_out", 64'(out), 64'(16'hA000 + b));
            @(negedge clk);
            set_word(2, 16'(16'hA000 + b + 1));
        end
        wait_load("burst_next", 3);
        req   = 8'h00;
        burst = 8'h00;
        repeat (3) @(negedge clk);
`endif

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0:       req = 8'h00;
                1:       req = 8'hFF;
                default: req = 8'($urandom);
            endcase
            burst = 8'($urandom);
            wdata = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 249) == 0) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
